swap_load_ctrl: RTL and testbench
=================================

Name: swap_load_ctrl

Overview:
Sequencing controller for the swap/load-word datapath. Owns an internal NREG x DATA_W register file and a temp register. Accepts one command at a time over a valid/ready handshake and runs it as a fixed multi-cycle micro-sequence:
- SWAP: temp <- Ra, Ra <- Rb, Rb <- temp.
- LOAD: Rd <- 0, then Rd <- Rd | data.

It sits between instruction decode and the register file, so decode never drives the swap/load stages directly.

Parameters:
DATA_W, 16, register and data width
NREG, 8, number of registers in the file
ADDR_W, 3, register address width (clog2 of NREG)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 NOP, 01 SWAP, 10 LOAD, 11 illegal
cmd_ra  in  ADDR_W  SWAP first register / LOAD destination
cmd_rb  in  ADDR_W  SWAP second register (ignored for LOAD)
cmd_data  in  DATA_W  LOAD data (ignored for SWAP)
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
err  out  1  valid only with done; 1 = illegal opcode
rd_addr  in  ADDR_W  debug/read port address
rd_data  out  DATA_W  combinational read: R[rd_addr]

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- While rst is high:
  - all registers and temp = 0;
  - state = IDLE, latched operands = 0;
  - cmd_ready = 0, busy = 0, done = 0, err = 0.
- Handshake:
  - cmd_ready = (state == IDLE) && !rst.
  - A command is accepted on a rising edge with cmd_valid && cmd_ready. op, ra, rb and data are latched at that edge.
  - Inputs are ignored while not ready.
- States: IDLE, SW_T, SW_A, SW_B, LD_CLR, LD_OR, FIN.
- IDLE, on accept:
  - SWAP -> SW_T; LOAD -> LD_CLR.
  - NOP -> FIN with err = 0; illegal -> FIN with err = 1.
  - NOP and illegal write nothing.
- SWAP sequence:
  - SW_T: temp <= R[ra]; -> SW_A.
  - SW_A: R[ra] <= R[rb]; -> SW_B.
  - SW_B: R[rb] <= temp; temp <= 0; -> FIN.
- LOAD sequence:
  - LD_CLR: R[ra] <= 0; -> LD_OR.
  - LD_OR: R[ra] <= R[ra] | data. R[ra] is 0 here, so the net result is R[ra] = data. -> FIN.
- FIN: done = 1 for exactly this cycle; err as latched; -> IDLE.
- Output timing: busy = 1 in every state except IDLE; done and err are registered state decodes.
- Latency, counted in edges after the accept edge:
  - SWAP: done high after edge 3; cmd_ready high after edge 4 (5 cycles accept-to-accept).
  - LOAD: done high after edge 2; ready after edge 3.
  - NOP/illegal: done high immediately after the accept edge; ready after edge 1.
- Boundary conditions:
  - SWAP with ra == rb: full sequence runs; register value unchanged.
  - Only one register-file write per cycle.
  - rd_data reflects writes from the cycle after the write edge. During a SWAP, R[ra] shows R[rb]'s old value between SW_A and SW_B (intermediate state is visible).
  - Addresses >= NREG (when NREG < 2^ADDR_W) are treated as illegal: FIN with err = 1, no writes.
  - Reset asserted mid-sequence aborts immediately. No done pulse is generated; all registers clear.
  - cmd_valid held high continuously: back-to-back commands are accepted on each IDLE cycle, with no bubble beyond FIN -> IDLE.
- Width: all datapath values are DATA_W; no arithmetic carries; OR is bitwise.

Test Plan:
- Reset: assert rst mid-cycle with R[2] previously loaded -> all outputs 0 asynchronously; after release, rd_data for every address = 0 and cmd_ready = 1 at the next edge.
- LOAD: LOAD ra=3 data=16'hA5C3 onto R[3]=16'hFFFF -> R[3]=0 after LD_CLR, then 16'hA5C3 after LD_OR; done one cycle at accept+2; err = 0.
- SWAP: R[1]=16'h1234, R[6]=16'hBEEF, SWAP 1,6 -> R[1]=16'hBEEF, R[6]=16'h1234; done at accept+3; busy high 4 cycles.
- SWAP ra == rb: R[4]=16'h00F0, SWAP 4,4 -> R[4]=16'h00F0; done at accept+3.
- Illegal and NOP: cmd_op=11 -> done+err at accept+0, no register change. cmd_op=00 -> done with err = 0.
- Back-to-back and abort:
  - cmd_valid held high with LOAD, SWAP, LOAD -> each accepted only when cmd_ready; final register values match sequential semantics.
  - rst pulsed during SW_A -> no done; all registers 0.

Source files
------------

// File: rtl/swap_load_ctrl_if.sv
// Command / status / debug-read bundle between instruction decode and
// the swap/load sequencing controller.
interface swap_load_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // Decode side: issues commands and reads back registers.
  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_data, rd_addr,
    input  cmd_ready, busy, done, err, rd_data
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_data, rd_addr,
    output cmd_ready, busy, done, err, rd_data
  );

endinterface

// File: rtl/swap_load_ctrl.sv
// Swap/load sequencing controller. Owns an NREG x DATA_W register file
// plus a temp register and runs each accepted command as a fixed
// multi-cycle micro-sequence with a single register-file write port.
module swap_load_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  swap_load_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SW_T, SW_A, SW_B, LD_CLR, LD_OR, FIN
  } state_t;

  localparam logic [1:0] OP_SWAP = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // One extra bit so addresses can be compared against NREG even when
  // NREG == 2**ADDR_W.
  localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W + 1)'(NREG);

  state_t            state, next_state;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] temp;
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              accept;
  logic              ra_bad, rb_bad, cmd_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              temp_ld, temp_clr;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // Out-of-range addresses make the command illegal; rb only matters for SWAP.
  assign ra_bad  = {1'b0, bus.cmd_ra} >= NREG_LIM;
  assign rb_bad  = {1'b0, bus.cmd_rb} >= NREG_LIM;
  assign cmd_err = (bus.cmd_op == OP_ILL)
                || ((bus.cmd_op == OP_SWAP) && (ra_bad || rb_bad))
                || ((bus.cmd_op == OP_LOAD) && ra_bad);

  // Status outputs are pure decodes of the registered state.
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);
  assign bus.err  = (state == FIN) && err_q;

  assign bus.rd_data = ({1'b0, bus.rd_addr} < NREG_LIM) ? regs[bus.rd_addr] : '0;

  // Next-state and micro-op decode: at most one register-file write per cycle.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    next_state = state;
    wr_en      = 1'b0;
    wr_addr    = ra_q;
    wr_data    = '0;
    temp_ld    = 1'b0;
    temp_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_err)                    next_state = FIN;
          else if (bus.cmd_op == OP_SWAP) next_state = SW_T;
          else if (bus.cmd_op == OP_LOAD) next_state = LD_CLR;
          else                            next_state = FIN;  // NOP
        end
      end
      SW_T: begin
        temp_ld    = 1'b1;
        next_state = SW_A;
      end
      SW_A: begin
        wr_en      = 1'b1;
        wr_addr    = ra_q;
        wr_data    = regs[rb_q];
        next_state = SW_B;
      end
      SW_B: begin
        wr_en      = 1'b1;
        wr_addr    = rb_q;
        wr_data    = temp;
        temp_clr   = 1'b1;
        next_state = FIN;
      end
      LD_CLR: begin
        wr_en      = 1'b1;
        wr_addr    = ra_q;
        wr_data    = '0;
        next_state = LD_OR;
      end
      LD_OR: begin
        wr_en      = 1'b1;
        wr_addr    = ra_q;
        wr_data    = regs[ra_q] | data_q;
        next_state = FIN;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of evaluation order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operand latch, captured only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      ra_q   <= bus.cmd_ra;
      rb_q   <= bus.cmd_rb;
      data_q <= bus.cmd_data;
      err_q  <= cmd_err;
    end
  end

  // Temp register holding R[ra] across the SWAP sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           temp <= '0;
    else if (temp_ld)  temp <= regs[ra_q];
    else if (temp_clr) temp <= '0;
  end

  // Register file with a single write port.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the file must clear on reset, so it is built from resettable
    // flops; a RAM macro could not be cleared in one cycle.
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_swap_load_ctrl.sv
// Self-checking bench for swap_load_ctrl: directed cases plus randomized
// commands, checked by a scoreboard fed from a behavioural register model.
module tb_swap_load_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] SWAP = 2'b01;
  localparam logic [1:0] LOAD = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

  typedef struct {
    logic          err;
    int            lat;
    int            nchk;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] v0, v1;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  swap_load_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  swap_load_ctrl #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] model [NR];

  logic          mon_sel = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  logic [AW-1:0] main_addr = '0;
  assign bus.rd_addr = mon_sel ? mon_addr : main_addr;

  bit prev_hold = 1'b0;
  int last_acc  = 0;
  int last_lat  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks err,
  // latency and the affected registers through the read port.
  always @(negedge clk) begin
    if (bus.done) begin
      check("done_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_err", bus.err, e.err);
        check("done_latency", cyc - e.acc, e.lat);
        mon_sel  = 1'b1;
        mon_addr = e.a0;
        #1 check("reg_a", bus.rd_data, e.v0);
        if (e.nchk == 2) begin
          mon_addr = e.a1;
          #1 check("reg_b", bus.rd_data, e.v1);
        end
        mon_sel = 1'b0;
      end
    end else begin
      check("err_without_done", bus.err, 0);
    end
  end

  // Drive one command and hold it until accepted; optionally push the
  // model's expected outcome. hold keeps cmd_valid high afterwards.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [DW-1:0] data, input bit hold, input bit push);
    bit            got;
    int            acc, lat;
    exp_t          e;
    logic [DW-1:0] t;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_data  = data;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ready_seen", got, 1);
    if (!got) begin
      bus.cmd_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    acc = cyc + 1;
    lat = (op == SWAP) ? 3 : (op == LOAD) ? 2 : 0;
    if (prev_hold) check("b2b_accept_edge", acc, last_acc + last_lat + 2);
    if (push) begin
      e.acc = acc;
      e.lat = lat;
      e.err = (op == ILL);
      e.a0  = ra;
      e.a1  = rb;
      case (op)
        SWAP: begin
          t         = model[ra];
          model[ra] = model[rb];
          model[rb] = t;
          e.nchk    = 2;
        end
        LOAD: begin
          model[ra] = data;
          e.nchk    = 1;
        end
        default: e.nchk = 1;
      endcase
      e.v0 = model[ra];
      e.v1 = model[rb];
      sb_q.push_back(e);
    end
    last_acc  = acc;
    last_lat  = lat;
    prev_hold = hold;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < NR; a++) begin
      main_addr = AW'(a);
      #1 check(name, bus.rd_data, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = NOP;
    bus.cmd_ra    = '0;
    bus.cmd_rb    = '0;
    bus.cmd_data  = '0;
    for (int a = 0; a < NR; a++) model[a] = '0;

    // Reset state.
    #2 check("rst_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.cmd_ready, 1);
    check_all_zero("rd_after_rst");

    // LOAD onto a non-zero register; clear stage is visible.
    issue(LOAD, 3'd3, 3'd0, 16'hFFFF, 1'b0, 1'b1);
    wait_idle();
    issue(LOAD, 3'd3, 3'd5, 16'hA5C3, 1'b0, 1'b1);
    @(negedge clk);
    main_addr = 3'd3;
    #1 check("ld_before_clr", bus.rd_data, 16'hFFFF);
    @(negedge clk);
    #1 check("ld_after_clr", bus.rd_data, 16'h0000);
    wait_idle();

    // SWAP 1,6 with busy profile and intermediate visibility.
    issue(LOAD, 3'd1, 3'd0, 16'h1234, 1'b0, 1'b1);
    wait_idle();
    issue(LOAD, 3'd6, 3'd0, 16'hBEEF, 1'b0, 1'b1);
    wait_idle();
    issue(SWAP, 3'd1, 3'd6, 16'h0000, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check("swap_busy", bus.busy, (n <= 4) ? 1 : 0);
      if (n == 3) begin
        main_addr = 3'd1;
        #1 check("swap_mid_ra", bus.rd_data, 16'hBEEF);
        main_addr = 3'd6;
        #1 check("swap_mid_rb", bus.rd_data, 16'hBEEF);
      end
    end
    wait_idle();

    // SWAP with ra == rb.
    issue(LOAD, 3'd4, 3'd0, 16'h00F0, 1'b0, 1'b1);
    wait_idle();
    issue(SWAP, 3'd4, 3'd4, 16'h0000, 1'b0, 1'b1);
    wait_idle();

    // Illegal and NOP.
    issue(ILL, 3'd3, 3'd1, 16'h1111, 1'b0, 1'b1);
    wait_idle();
    issue(NOP, 3'd6, 3'd2, 16'h2222, 1'b0, 1'b1);
    wait_idle();

    // Back-to-back with cmd_valid held high.
    issue(LOAD, 3'd0, 3'd0, 16'hCAFE, 1'b1, 1'b1);
    issue(SWAP, 3'd0, 3'd7, 16'h0000, 1'b1, 1'b1);
    issue(LOAD, 3'd7, 3'd0, 16'h1357, 1'b0, 1'b1);
    wait_idle();

    // Randomized commands, mixing held-valid and gapped issue.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]    op;
      logic [AW-1:0] ra, rb;
      logic [DW-1:0] d;
      bit            hold;
      op   = 2'($urandom_range(0, 3));
      ra   = AW'($urandom_range(0, NR - 1));
      rb   = AW'($urandom_range(0, NR - 1));
      d    = DW'($urandom);
      hold = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(op, ra, rb, d, hold, 1'b1);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Abort: reset during SW_A, no done, everything clears.
    issue(LOAD, 3'd2, 3'd0, 16'h5A5A, 1'b0, 1'b1);
    wait_idle();
    issue(SWAP, 3'd2, 3'd5, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.err}, 0);
    main_addr = 3'd2;
    #1 check("abort_r2", bus.rd_data, 0);
    for (int a = 0; a < NR; a++) model[a] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("ready_after_abort", bus.cmd_ready, 1);
    check_all_zero("rd_after_abort");

    // Controller works again after the abort.
    issue(LOAD, 3'd2, 3'd0, 16'h0F0F, 1'b0, 1'b1);
    wait_idle();

    check("pending_expectations", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
